regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard.sv | 97 +++++++++
 tb/tb_regfile_scoreboard.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : NREGS x XLEN register file with per-register busy scoreboard,
//               combinational reads and registered busy population count.
//               Optional write-to-read forwarding: define REGFILE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] WriteData,
    input  logic            RegWrite,
    input  logic            IssueValid,
    input  logic [AW-1:0]   IssueRd,
    output logic [XLEN-1:0] ReadData1,
    output logic [XLEN-1:0] ReadData2,
    output logic            Busy1,
    output logic            Busy2,
    output logic [AW:0]     BusyCount
);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_next;
    logic [AW:0]      r_busy_count;
    logic [AW:0]      w_busy_count_next;
    logic             w_wr_en;
    logic             w_issue_en;

    assign w_wr_en    = RegWrite && (rd != '0);
    assign w_issue_en = IssueValid && (IssueRd != '0);

    // Clear first so that a same-cycle issue to the same register wins.
    always_comb begin
        w_busy_next = r_busy;
        if (w_wr_en) begin
            w_busy_next[rd] = 1'b0;
        end
        if (w_issue_en) begin
            w_busy_next[IssueRd] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    always_comb begin
        w_busy_count_next = '0;
        for (int i = 0; i < NREGS; i++) begin
            w_busy_count_next = w_busy_count_next + (AW+1)'(w_busy_next[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            if (w_wr_en) begin
                r_regs[rd] <= WriteData;
            end
            r_busy       <= w_busy_next;
            r_busy_count <= w_busy_count_next;
        end
    end

    always_comb begin
        ReadData1 = (rs1 == '0) ? '0 : r_regs[rs1];
        ReadData2 = (rs2 == '0) ? '0 : r_regs[rs2];
        Busy1     = r_busy[rs1];
        Busy2     = r_busy[rs2];
`ifdef REGFILE_BYPASS_EN
        // Forward the in-flight write-back; its register is no longer pending.
        if (w_wr_en && !reset && (rd == rs1)) begin
            ReadData1 = WriteData;
            Busy1     = 1'b0;
        end
        if (w_wr_en && !reset && (rd == rs2)) begin
            ReadData2 = WriteData;
            Busy2     = 1'b0;
        end
`endif
    end

    assign BusyCount = r_busy_count;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_scoreboard
// Description : Self-checking bench for regfile_scoreboard (directed + random).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic [AW-1:0]   rs1, rs2, rd, IssueRd;
    logic [XLEN-1:0] WriteData;
    logic            RegWrite, IssueValid;
    logic [XLEN-1:0] ReadData1, ReadData2;
    logic            Busy1, Busy2;
    logic [AW:0]     BusyCount;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_busy [NREGS];

    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
        .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .rd(rd),
        .WriteData(WriteData), .RegWrite(RegWrite), .IssueValid(IssueValid),
        .IssueRd(IssueRd), .ReadData1(ReadData1), .ReadData2(ReadData2),
        .Busy1(Busy1), .Busy2(Busy2), .BusyCount(BusyCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural state updated from the rules at each edge.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (RegWrite && rd != 0) begin
                m_regs[rd] = WriteData;
                m_busy[rd] = 1'b0;
            end
            if (IssueValid && IssueRd != 0) m_busy[IssueRd] = 1'b1;
        end
    end

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < NREGS; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic logic [XLEN-1:0] model_rd(input logic [AW-1:0] a);
        logic [XLEN-1:0] v;
        v = (a == 0) ? '0 : m_regs[a];
`ifdef REGFILE_BYPASS_EN
        if (RegWrite && !reset && rd != 0 && rd == a) v = WriteData;
`endif
        return v;
    endfunction

    function automatic bit model_busy(input logic [AW-1:0] a);
        bit b;
        b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
        if (RegWrite && !reset && rd != 0 && rd == a) b = 1'b0;
`endif
        return b;
    endfunction

    // Compare process: every cycle once the model has been reset.
    always @(negedge clk) begin
        if (started) begin
            check("rd1",   ReadData1, model_rd(rs1));
            check("rd2",   ReadData2, model_rd(rs2));
            check("busy1", XLEN'(Busy1), XLEN'(model_busy(rs1)));
            check("busy2", XLEN'(Busy2), XLEN'(model_busy(rs2)));
            check("bcount", XLEN'(BusyCount), XLEN'(model_count()));
        end
    end

    task automatic idle();
        RegWrite = 1'b0; IssueValid = 1'b0; rd = '0; IssueRd = '0; WriteData = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [XLEN-1:0] exp_byp;

    initial begin
        reset = 1'b1; rs1 = 5'd5; rs2 = 5'd31;
        idle();
        step();
        started = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("reset_rd1", ReadData1, 64'd0);
        check("reset_rd2", ReadData2, 64'd0);
        check("reset_bc", XLEN'(BusyCount), 64'd0);
        check("reset_busy1", XLEN'(Busy1), 64'd0);

        // Register 0 is hardwired.
        step();
        RegWrite = 1'b1; rd = 5'd0; WriteData = '1;
        IssueValid = 1'b1; IssueRd = 5'd0;
        step();
        idle(); rs1 = 5'd0;
        @(negedge clk);
        check("x0_read", ReadData1, 64'd0);
        check("x0_bc", XLEN'(BusyCount), 64'd0);

        // Issue 7 then 9, write back 7.
        step();
        IssueValid = 1'b1; IssueRd = 5'd7;
        step();
        IssueRd = 5'd9;
        step();
        idle(); rs1 = 5'd7;
        @(negedge clk);
        check("two_busy_bc", XLEN'(BusyCount), 64'd2);
        check("two_busy_b1", XLEN'(Busy1), 64'd1);
        step();
        RegWrite = 1'b1; rd = 5'd7; WriteData = 64'h1234;
        step();
        idle();
        @(negedge clk);
        check("wb7_bc", XLEN'(BusyCount), 64'd1);
        check("wb7_rd1", ReadData1, 64'h1234);

        // Same-cycle issue and write-back to busy register 4: set wins.
        step();
        IssueValid = 1'b1; IssueRd = 5'd4;
        step();
        RegWrite = 1'b1; rd = 5'd4; WriteData = 64'h55;
        step();
        idle(); rs1 = 5'd4;
        @(negedge clk);
        check("collide_busy", XLEN'(Busy1), 64'd1);
        check("collide_bc", XLEN'(BusyCount), 64'd2);
        check("collide_data", ReadData1, 64'h55);

        // Write to register 3 observed in the same cycle.
        step();
        RegWrite = 1'b1; rd = 5'd3; WriteData = 64'hABCD; rs1 = 5'd3;
`ifdef REGFILE_BYPASS_EN
        exp_byp = 64'hABCD;
`else
        exp_byp = 64'h0;
`endif
        @(negedge clk);
        check("same_cycle_rd1", ReadData1, exp_byp);
        step();
        idle();
        @(negedge clk);
        check("next_cycle_rd1", ReadData1, 64'hABCD);

        // Three busy (4, 9, 12), then a one-cycle reset.
        step();
        IssueValid = 1'b1; IssueRd = 5'd12;
        step();
        idle();
        @(negedge clk);
        check("three_busy_bc", XLEN'(BusyCount), 64'd3);
        step();
        reset = 1'b1; RegWrite = 1'b1; rd = 5'd5; WriteData = 64'h77;
        IssueValid = 1'b1; IssueRd = 5'd6;
        step();
        reset = 1'b0; idle();
        @(negedge clk);
        check("post_reset_bc", XLEN'(BusyCount), 64'd0);
        for (int i = 0; i < NREGS; i++) begin
            rs1 = AW'(i); rs2 = AW'(NREGS - 1 - i);
            #0.1;
            check("post_reset_reg", ReadData1 | ReadData2, 64'd0);
        end
        step();
        // Formerly busy register 9: data lands, count stays 0.
        RegWrite = 1'b1; rd = 5'd9; WriteData = 64'h99;
        step();
        idle(); rs1 = 5'd9;
        @(negedge clk);
        check("abandon_bc", XLEN'(BusyCount), 64'd0);
        check("abandon_rd1", ReadData1, 64'h99);

        // Randomized phase; addresses biased to a small window for collisions.
        for (int n = 0; n < 3000; n++) begin
            step();
            reset      = ($urandom_range(0, 99) == 0);
            RegWrite   = $urandom_range(0, 1) == 1;
            IssueValid = $urandom_range(0, 2) != 0;
            if ($urandom_range(0, 1) == 1) begin
                rd = AW'($urandom_range(0, 5)); IssueRd = AW'($urandom_range(0, 5));
                rs1 = AW'($urandom_range(0, 5)); rs2 = AW'($urandom_range(0, 5));
            end else begin
                rd = AW'($urandom); IssueRd = AW'($urandom);
                rs1 = AW'($urandom); rs2 = AW'($urandom);
            end
            WriteData = {$urandom, $urandom};
        end
        step();
        idle(); reset = 1'b0;
        step();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
